signal_color_pipe: RTL and testbench

//  Pipelined, multi-channel successor to the combinational pixel colouriser.

---
 rtl/cm_pkg.sv | 27 ++
 rtl/cm_lerp8.sv | 44 ++++
 rtl/signal_color_pipe.sv | 122 ++++++++++++
 tb/tb_signal_color_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared types and colour constants for the signal colour pipeline.
// The palette entries for channels 2 and 3 are local choices, since only channels 0 and 1 are pinned.
package cm_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    K_ANT   = 2'd0,
    K_SUGAR = 2'd1,
    K_NEST  = 2'd2,
    K_SIG   = 2'd3
  } kind_t;

  // Element [k] is channel k: ch0 green->cyan, ch1 green->amber, ch2/ch3 blue and magenta ramps.
  localparam rgb_t [3:0] PAL_LO = {24'h330033, 24'h000033, 24'h669900, 24'h669900};
  localparam rgb_t [3:0] PAL_HI = {24'hFF33CC, 24'h3366FF, 24'hFFCC33, 24'h66FFFF};

  localparam rgb_t C_ANT       = 24'h000000;
  localparam rgb_t C_SUGAR     = 24'hFFFFFF;
  localparam rgb_t C_NEST      = 24'h8B4513;
  localparam rgb_t C_ANT_BLINK = 24'hFF0000;

endpackage

// File: rtl/cm_lerp8.sv
// One 8-bit colour component lerp: S2 registers LO and (HI-LO)*t, S3 registers LO + (prod >>> 8).
// Fixed colours pass through with LO == HI, so delta and prod are zero.
module cm_lerp8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_s2,
  input  logic       en_s3,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic [7:0] t,
  output logic [7:0] c
);

  logic        [7:0]  lo_q, lo_d;
  logic signed [16:0] prod_q, prod_d;
  logic        [7:0]  c_q, c_d;
  logic signed [8:0]  delta;
  logic signed [16:0] delta_x, t_x;

  always_comb begin
    delta   = $signed({1'b0, hi}) - $signed({1'b0, lo});
    delta_x = {{8{delta[8]}}, delta};
    t_x     = {9'b0, t};
    lo_d    = en_s2 ? lo : lo_q;
    prod_d  = en_s2 ? (delta_x * t_x) : prod_q;
    // Floor of delta*t/256 never leaves [delta, 0] or [0, delta], so the sum stays in 0..255.
    c_d     = en_s3 ? 8'($signed({9'b0, lo_q}) + (prod_q >>> 8)) : c_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= '0;
      prod_q <= '0;
      c_q    <= '0;
    end else begin
      lo_q   <= lo_d;
      prod_q <= prod_d;
      c_q    <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: rtl/signal_color_pipe.sv
// Pipelined pixel colouriser: S1 classify/clamp, S2 lerp multiply, S3 add and drive VGA.
// Optional ant blinking is enabled with the CM_BLINK_EN macro.
module signal_color_pipe
  import cm_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int SIG_W      = 10,
  parameter int DISP_MIN   = 8,
  parameter int SPAN_LOG2  = 9,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    in_valid,
  input  logic                    renderAnt,
  input  logic                    renderSugar,
  input  logic                    renderNest,
  input  logic [N_CH*SIG_W-1:0]   renderSignal,
  input  logic                    frame_start,
  output logic                    out_valid,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B
);

  localparam int DISP_MAX = DISP_MIN + 2 ** SPAN_LOG2;
  localparam int SH_R     = (SPAN_LOG2 >= 8) ? SPAN_LOG2 - 8 : 0;
  localparam int SH_L     = (SPAN_LOG2 >= 8) ? 0 : 8 - SPAN_LOG2;

  kind_t              kind_q, kind_d;
  logic [1:0]         ch_q, ch_d;
  logic [7:0]         t_q, t_d;
  logic               blink_q, blink_d;
  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [SIG_W-1:0]   best_lvl;
  logic [SPAN_LOG2-1:0] span_d;
  rgb_t               lo, hi;

  // S1: channel arbitration (strict > keeps the lowest index on ties) and level clamp.
  always_comb begin
    best_lvl = renderSignal[0 +: SIG_W];
    ch_d     = 2'd0;
    for (int k = 1; k < N_CH; k++) begin
      if (renderSignal[k*SIG_W +: SIG_W] > best_lvl) begin
        best_lvl = renderSignal[k*SIG_W +: SIG_W];
        ch_d     = 2'(k);
      end
    end
    span_d = SPAN_LOG2'(32'(best_lvl) - 32'(DISP_MIN));
    if (renderAnt)        kind_d = K_ANT;
    else if (renderSugar) kind_d = K_SUGAR;
    else if (renderNest)  kind_d = K_NEST;
    else                  kind_d = K_SIG;
    if (kind_d != K_SIG || 32'(best_lvl) < 32'(DISP_MIN)) t_d = 8'd0;
    else if (32'(best_lvl) >= 32'(DISP_MAX))              t_d = 8'd255;
    else                                                  t_d = 8'((32'(span_d) >> SH_R) << SH_L);
    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;
  end

`ifdef CM_BLINK_EN
  logic [BLINK_LOG2:0] frame_cnt_q, frame_cnt_d;

  // The pixel sees the counter value before any coincident frame_start increment.
  always_comb begin
    frame_cnt_d = frame_cnt_q + (BLINK_LOG2+1)'(frame_start);
    blink_d     = frame_cnt_q[BLINK_LOG2];
  end

  always_ff @(posedge Clk) begin
    if (Reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = frame_start ^ (BLINK_LOG2 > 0);
  always_comb blink_d = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kind_q  <= K_ANT;
      ch_q    <= '0;
      t_q     <= '0;
      blink_q <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
    end else begin
      kind_q  <= kind_d;
      ch_q    <= ch_d;
      t_q     <= t_d;
      blink_q <= blink_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
    end
  end

  // Palette endpoints feeding S2; fixed colours use LO == HI.
  always_comb begin
    lo = PAL_LO[ch_q];
    hi = PAL_HI[ch_q];
    case (kind_q)
      K_ANT:   begin lo = blink_q ? C_ANT_BLINK : C_ANT; hi = lo; end
      K_SUGAR: begin lo = C_SUGAR; hi = lo; end
      K_NEST:  begin lo = C_NEST;  hi = lo; end
      default: ;
    endcase
  end

  cm_lerp8 u_lerp_r (.clk(Clk), .rst(Reset), .en_s2(v1_q), .en_s3(v2_q),
                     .lo(lo.r), .hi(hi.r), .t(t_q), .c(VGA_R));
  cm_lerp8 u_lerp_g (.clk(Clk), .rst(Reset), .en_s2(v1_q), .en_s3(v2_q),
                     .lo(lo.g), .hi(hi.g), .t(t_q), .c(VGA_G));
  cm_lerp8 u_lerp_b (.clk(Clk), .rst(Reset), .en_s2(v1_q), .en_s3(v2_q),
                     .lo(lo.b), .hi(hi.b), .t(t_q), .c(VGA_B));

  assign out_valid = v3_q;

endmodule

// File: tb/tb_signal_color_pipe.sv
// Directed bench for signal_color_pipe (N_CH=2, SIG_W=10, DISP_MIN=8, SPAN_LOG2=9, BLINK_LOG2=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_signal_color_pipe;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        renderAnt = 1'b0;
  logic        renderSugar = 1'b0;
  logic        renderNest = 1'b0;
  logic [19:0] renderSignal = '0;
  logic        frame_start = 1'b0;
  logic        out_valid;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  signal_color_pipe #(
    .N_CH(2), .SIG_W(10), .DISP_MIN(8), .SPAN_LOG2(9), .BLINK_LOG2(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid),
    .renderAnt(renderAnt), .renderSugar(renderSugar), .renderNest(renderNest),
    .renderSignal(renderSignal), .frame_start(frame_start),
    .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_pixel(input logic a, input logic s, input logic n,
                           input logic [9:0] c0, input logic [9:0] c1);
    renderAnt    = a;
    renderSugar  = s;
    renderNest   = n;
    renderSignal = {c1, c0};
  endtask

  // Present one pixel for one cycle and return what appears three edges later.
  task automatic run_pixel(input logic a, input logic s, input logic n,
                           input logic [9:0] c0, input logic [9:0] c1, input logic fs,
                           output logic ov, output logic [23:0] rgb);
    set_pixel(a, s, n, c0, c1);
    in_valid    = 1'b1;
    frame_start = fs;
    tick();
    in_valid    = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    ov  = out_valid;
    rgb = {VGA_R, VGA_G, VGA_B};
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_pixel(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    in_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      failures++;
      $display("FAIL reset: out_valid=%b rgb=%h expected 0 / 000000", out_valid, {VGA_R, VGA_G, VGA_B});
    end
    in_valid = 1'b0;
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_gradient();
    logic [9:0]  c0 [7];
    logic [9:0]  c1 [7];
    logic [23:0] exp_rgb [7];
    logic        ov;
    logic [23:0] rgb;
    c0 = '{10'd264, 10'd3,   10'd600, 10'd264, 10'd264, 10'd8,   10'd519};
    c1 = '{10'd0,   10'd5,   10'd0,   10'd264, 10'd300, 10'd0,   10'd0};
    exp_rgb = '{24'h66CC7F, 24'h669900, 24'h66FEFE, 24'h66CC7F, 24'hBDB61D, 24'h669900, 24'h66FEFE};
    for (int i = 0; i < 7; i++) begin
      run_pixel(1'b0, 1'b0, 1'b0, c0[i], c1[i], 1'b0, ov, rgb);
      checks++;
      if (ov !== 1'b1 || rgb !== exp_rgb[i]) begin
        failures++;
        $display("FAIL gradient[%0d] ch0=%0d ch1=%0d: out_valid=%b rgb=%h expected 1 / %h",
                 i, c0[i], c1[i], ov, rgb, exp_rgb[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic        ov;
    logic [23:0] rgb;
    run_pixel(1'b1, 1'b1, 1'b1, 10'd264, 10'd300, 1'b0, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'h000000) begin
      failures++;
      $display("FAIL prio_ant: out_valid=%b rgb=%h expected 1 / 000000", ov, rgb);
    end
    run_pixel(1'b0, 1'b1, 1'b1, 10'd264, 10'd0, 1'b0, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL prio_sugar: out_valid=%b rgb=%h expected 1 / FFFFFF", ov, rgb);
    end
    run_pixel(1'b0, 1'b0, 1'b1, 10'd600, 10'd0, 1'b0, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'h8B4513) begin
      failures++;
      $display("FAIL prio_nest: out_valid=%b rgb=%h expected 1 / 8B4513", ov, rgb);
    end
  endtask

  task automatic test_hold();
    logic        ov;
    logic [23:0] rgb;
    run_pixel(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, ov, rgb);
    tick();
    checks++;
    if (out_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL hold: out_valid=%b rgb=%h expected 0 / FFFFFF", out_valid, {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pat_rgb [5];
    logic [23:0] got, want;
    logic        exp_ov;
    pat_rgb = '{24'h000000, 24'hFFFFFF, 24'h8B4513, 24'h66CC7F, 24'h66FEFE};
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      case (i % 5)
        0: set_pixel(1'b1, 1'b0, 1'b0, 10'd0,   10'd0);
        1: set_pixel(1'b0, 1'b1, 1'b0, 10'd0,   10'd0);
        2: set_pixel(1'b0, 1'b0, 1'b1, 10'd0,   10'd0);
        3: set_pixel(1'b0, 1'b0, 1'b0, 10'd264, 10'd0);
        default: set_pixel(1'b0, 1'b0, 1'b0, 10'd600, 10'd0);
      endcase
      in_valid = 1'b1;
      Reset = (i == 5);
      if (i != 5) exp_q.push_back(pat_rgb[i % 5]);
      tick();
      got = {VGA_R, VGA_G, VGA_B};
      if (i == 5) begin
        // Pixels 3 and 4 were in flight and must vanish with the reset.
        exp_q.delete();
        Reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || got !== 24'h0) begin
          failures++;
          $display("FAIL b2b_reset: out_valid=%b rgb=%h expected 0 / 000000", out_valid, got);
        end
      end else begin
        exp_ov = (i >= 2 && i < 5) || (i >= 8);
        checks++;
        if (out_valid !== exp_ov) begin
          failures++;
          $display("FAIL b2b_valid[%0d]: out_valid=%b expected %b", i, out_valid, exp_ov);
        end else if (exp_ov) begin
          want = exp_q.pop_front();
          checks++;
          if (got !== want) begin
            failures++;
            $display("FAIL b2b_rgb[%0d]: rgb=%h expected %h", i, got, want);
          end
        end
      end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      exp_ov = (j < 2);
      got = {VGA_R, VGA_G, VGA_B};
      checks++;
      if (out_valid !== exp_ov) begin
        failures++;
        $display("FAIL b2b_drain_valid[%0d]: out_valid=%b expected %b", j, out_valid, exp_ov);
      end else if (exp_ov) begin
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL b2b_drain_rgb[%0d]: rgb=%h expected %h", j, got, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_leftover: %0d pixels never emerged, expected 0", exp_q.size());
    end
  endtask

`ifdef CM_BLINK_EN
  task automatic test_blink();
    logic        ov;
    logic [23:0] rgb;
    pulse_frames(1);
    // Counter is 1 here; the coincident pulse must not affect this pixel.
    run_pixel(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'h000000) begin
      failures++;
      $display("FAIL blink_coincident: out_valid=%b rgb=%h expected 1 / 000000", ov, rgb);
    end
    run_pixel(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'hFF0000) begin
      failures++;
      $display("FAIL blink_on: out_valid=%b rgb=%h expected 1 / FF0000", ov, rgb);
    end
    pulse_frames(2);
    run_pixel(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'h000000) begin
      failures++;
      $display("FAIL blink_off: out_valid=%b rgb=%h expected 1 / 000000", ov, rgb);
    end
  endtask
`else
  task automatic test_blink();
    logic        ov;
    logic [23:0] rgb;
    pulse_frames(2);
    run_pixel(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, ov, rgb);
    checks++;
    if (ov !== 1'b1 || rgb !== 24'h000000) begin
      failures++;
      $display("FAIL blink_disabled: out_valid=%b rgb=%h expected 1 / 000000", ov, rgb);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_gradient();
    test_priority();
    test_hold();
    test_back_to_back();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
